// File: rtl/pulse_counter_mod.sv
// -----------------------------------------------------------------------------
// pulse_counter_mod
//
// Configurable event tally. Counts qualified din events modulo MODULUS in the
// direction selected by up_dn, with synchronous clear/load, terminal-count,
// wrap pulse and sticky overflow reporting. SATURATE selects hold-at-end
// instead of wrap-around; EDGE_MODE qualifies din on its 0->1 transition.
//
// Parameters
//   WIDTH     counter width, 2..16
//   MODULUS   count range 0..MODULUS-1, 2..2^WIDTH
//   SATURATE  0 = wrap at range ends, 1 = hold at range ends
//   EDGE_MODE 0 = din level is the event, 1 = din rising edge is the event
//
// Ports
//   clk       sole clock, rising edge
//   reset_n   asynchronous active-low reset
//   din       event input
//   up_dn     direction, 1 = up, 0 = down
//   clear     synchronous clear (highest priority)
//   load      synchronous load of load_val (clamped to MODULUS-1)
//   load_val  value to load
//   z         registered count
//   tc        terminal count for the current direction (combinational)
//   wrap      one-cycle registered pulse after a wrap or blocked event
//   ovf       sticky overflow, cleared by clear or reset
// -----------------------------------------------------------------------------
module pulse_counter_mod #(
  parameter int WIDTH     = 4,
  parameter int MODULUS   = 16,
  parameter bit SATURATE  = 1'b0,
  parameter bit EDGE_MODE = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             din,
  input  logic             up_dn,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] z,
  output logic             tc,
  output logic             wrap,
  output logic             ovf
);

  // MODULUS may equal 2^WIDTH, so the load comparison needs one extra bit.
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

  logic             event_q;
  logic [WIDTH-1:0] z_nxt;
  logic             wrap_nxt;
  logic             ovf_nxt;
  logic [WIDTH-1:0] load_clamped;
  logic             at_end;

  // ---------------------------------------------------------------------------
  // Event qualification
  // ---------------------------------------------------------------------------
  generate
    if (EDGE_MODE) begin : g_edge
      logic din_q;

      // din_q tracks din every cycle, independent of clear/load, so an edge
      // coinciding with a clear or load is consumed rather than deferred.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          din_q <= 1'b0;
        end else begin
          din_q <= din;
        end
      end

      assign event_q = din & ~din_q;
    end else begin : g_level
      assign event_q = din;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Next-state computation: clear > load > event > hold
  // ---------------------------------------------------------------------------
  assign load_clamped = ({1'b0, load_val} < MOD_EXT) ? load_val : MAX_VAL;

  // z never leaves 0..MAX_VAL, so equality with the range end is sufficient.
  assign at_end = up_dn ? (z == MAX_VAL) : (z == '0);

  always_comb begin
    z_nxt    = z;
    wrap_nxt = 1'b0;
    ovf_nxt  = ovf;
    if (clear) begin
      z_nxt   = '0;
      ovf_nxt = 1'b0;
    end else if (load) begin
      z_nxt = load_clamped;
    end else if (event_q) begin
      if (at_end) begin
        wrap_nxt = 1'b1;
        ovf_nxt  = 1'b1;
        if (!SATURATE) begin
          z_nxt = up_dn ? '0 : MAX_VAL;
        end
      end else begin
        z_nxt = up_dn ? (z + WIDTH'(1)) : (z - WIDTH'(1));
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      z    <= '0;
      wrap <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      z    <= z_nxt;
      wrap <= wrap_nxt;
      ovf  <= ovf_nxt;
    end
  end

  assign tc = at_end;

endmodule

// File: tb/tb_pulse_counter_mod.sv
module tb_pulse_counter_mod;

  localparam int N = 3;
  // Instance configurations: plain wrap/level, saturating mod-10, edge mod-12.
  localparam int PM [N] = '{16, 10, 12};
  localparam int PS [N] = '{0, 1, 0};
  localparam int PE [N] = '{0, 0, 1};

  logic       clk = 1'b0;
  logic       reset_n;
  logic       din;
  logic       up_dn;
  logic       clear;
  logic       load;
  logic [3:0] load_val;
  logic [3:0] zz [N];
  logic       tt [N];
  logic       ww [N];
  logic       oo [N];

  int checks = 0;
  int errors = 0;

  typedef struct {
    int z;
    bit w;
    bit o;
    bit t;
  } exp_t;

  exp_t q [N][$];

  // Reference model state
  int mz [N];
  bit mo [N];
  bit mprev;

  always #5 clk = ~clk;

  pulse_counter_mod #(.WIDTH(4), .MODULUS(16), .SATURATE(1'b0), .EDGE_MODE(1'b0)) u_wrap (
    .clk(clk), .reset_n(reset_n), .din(din), .up_dn(up_dn), .clear(clear), .load(load),
    .load_val(load_val), .z(zz[0]), .tc(tt[0]), .wrap(ww[0]), .ovf(oo[0]));

  pulse_counter_mod #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b1), .EDGE_MODE(1'b0)) u_sat (
    .clk(clk), .reset_n(reset_n), .din(din), .up_dn(up_dn), .clear(clear), .load(load),
    .load_val(load_val), .z(zz[1]), .tc(tt[1]), .wrap(ww[1]), .ovf(oo[1]));

  pulse_counter_mod #(.WIDTH(4), .MODULUS(12), .SATURATE(1'b0), .EDGE_MODE(1'b1)) u_edge (
    .clk(clk), .reset_n(reset_n), .din(din), .up_dn(up_dn), .clear(clear), .load(load),
    .load_val(load_val), .z(zz[2]), .tc(tt[2]), .wrap(ww[2]), .ovf(oo[2]));

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  // Drive one cycle of stimulus at the falling edge and queue the state each
  // instance should show after the following rising edge.
  task automatic cyc(input bit rst, input bit d, input bit up, input bit clr,
                     input bit ld, input int lv);
    bit   edge_ev;
    bit   ev;
    bit   w;
    int   t;
    exp_t e;
    @(negedge clk);
    reset_n  = rst;
    din      = d;
    up_dn    = up;
    clear    = clr;
    load     = ld;
    load_val = 4'(lv);
    edge_ev  = d && !mprev;
    for (int k = 0; k < N; k++) begin
      w  = 1'b0;
      ev = (PE[k] != 0) ? edge_ev : d;
      if (!rst || clr) begin
        mz[k] = 0;
        mo[k] = 1'b0;
      end else if (ld) begin
        mz[k] = (lv < PM[k]) ? lv : PM[k] - 1;
      end else if (ev) begin
        t = mz[k] + (up ? 1 : -1);
        if (t < 0 || t >= PM[k]) begin
          w     = 1'b1;
          mo[k] = 1'b1;
          if (PS[k] == 0) mz[k] = (t + PM[k]) % PM[k];
        end else begin
          mz[k] = t;
        end
      end
      e.z = mz[k];
      e.w = w;
      e.o = mo[k];
      e.t = up ? (mz[k] == PM[k] - 1) : (mz[k] == 0);
      q[k].push_back(e);
    end
    mprev = rst ? d : 1'b0;
  endtask

  task automatic chk_zero(input string tag, input bit up);
    for (int k = 0; k < N; k++) begin
      chk($sformatf("%s_z%0d", tag, k), int'(zz[k]), 0);
      chk($sformatf("%s_wrap%0d", tag, k), int'(ww[k]), 0);
      chk($sformatf("%s_ovf%0d", tag, k), int'(oo[k]), 0);
      chk($sformatf("%s_tc%0d", tag, k), int'(tt[k]), up ? 0 : 1);
    end
  endtask

  // Monitor: every instance presents a new state after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      for (int k = 0; k < N; k++) begin
        if (q[k].size() > 0) begin
          e = q[k].pop_front();
          chk($sformatf("z%0d", k), int'(zz[k]), e.z);
          chk($sformatf("wrap%0d", k), int'(ww[k]), int'(e.w));
          chk($sformatf("ovf%0d", k), int'(oo[k]), int'(e.o));
          chk($sformatf("tc%0d", k), int'(tt[k]), int'(e.t));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < N; k++) begin
      mz[k] = 0;
      mo[k] = 1'b0;
    end
    mprev    = 1'b0;
    reset_n  = 1'b0;
    din      = 1'b1;
    up_dn    = 1'b0;
    clear    = 1'b0;
    load     = 1'b0;
    load_val = '0;
    #1;
    chk_zero("rst_dn", 1'b0);
    up_dn = 1'b1;
    #1;
    chk_zero("rst_up", 1'b1);

    // din held high through reset; level instances count every cycle,
    // edge instance counts once.
    cyc(0, 1, 1, 0, 0, 0);
    for (int i = 0; i < 17; i++) cyc(1, 1, 1, 0, 0, 0);
    cyc(1, 0, 1, 0, 0, 0);

    // Edge pattern: high 5, low 2, high 1.
    cyc(1, 0, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(1, 1, 1, 0, 0, 0);
    for (int i = 0; i < 2; i++) cyc(1, 0, 1, 0, 0, 0);
    cyc(1, 1, 1, 0, 0, 0);
    cyc(1, 0, 1, 0, 0, 0);
    // Toggling din every cycle.
    for (int i = 0; i < 6; i++) cyc(1, i[0] == 1'b0, 1, 0, 0, 0);

    // Loads: in-range, clamped, and load with event.
    cyc(1, 0, 1, 0, 1, 9);
    cyc(1, 0, 1, 0, 0, 0);
    cyc(1, 0, 1, 0, 1, 12);
    cyc(1, 0, 1, 0, 1, 15);
    cyc(1, 1, 1, 0, 1, 5);
    cyc(1, 0, 1, 0, 0, 0);

    // Down count into saturation from 2.
    cyc(1, 0, 0, 0, 1, 2);
    for (int i = 0; i < 4; i++) cyc(1, 1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);

    // Asynchronous reset between edges at z=7.
    cyc(1, 0, 1, 0, 1, 7);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    chk_zero("midrst", 1'b1);
    cyc(0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(1, 1, 1, 0, 0, 0);

    // Overflow, then clear together with load and din.
    cyc(1, 0, 1, 0, 1, 15);
    cyc(1, 1, 1, 0, 0, 0);
    cyc(1, 1, 1, 0, 0, 0);
    cyc(1, 1, 1, 1, 1, 6);
    cyc(1, 0, 1, 0, 0, 0);

    // Randomized traffic.
    for (int i = 0; i < 800; i++) begin
      cyc(($urandom_range(0, 99) != 0),
          1'($urandom_range(0, 1)),
          ($urandom_range(0, 7) != 0) ? 1'b1 : 1'b0 ^ 1'($urandom_range(0, 1)) ^ 1'(i / 100),
          ($urandom_range(0, 39) == 0),
          ($urandom_range(0, 19) == 0),
          int'($urandom_range(0, 15)));
    end

    cyc(1, 0, 1, 0, 0, 0);
    @(posedge clk);
    #4;
    for (int k = 0; k < N; k++) chk($sformatf("drain%0d", k), q[k].size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
